// File: rtl/ads_adc_emu.sv
// ads_adc_emu: cycle-level emulation of a quad-lane serial ADC.
// A convst rising edge starts a fixed-length busy period. After that, an
// fs_n falling edge opens a frame. In the frame, each lane shifts out
// WORDS_PER_LANE 16-bit words, MSB first, one bit per sclk falling edge.
// Each word carries the lane index, the word index and a 12-bit frame counter.
module ads_adc_emu #(
   parameter int BUSY_CYCLES    = 54,
   parameter int WORDS_PER_LANE = 2
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic       ad_reset,
   input  logic       ad_convst,
   output logic       ad_busy,
   input  logic       ad_fs_n,
   input  logic       ad_sclk,
   input  logic       ad_sdi,
   output logic [3:0] ad_sdo,
   output logic       overrun
);

   typedef enum logic [1:0] {IDLE, CONV, READY, SHIFT} state_t;

   localparam int            BW        = (BUSY_CYCLES > 1) ? $clog2(BUSY_CYCLES) : 1;
   localparam logic [BW-1:0] BUSY_LAST = BW'(BUSY_CYCLES - 1);
   localparam logic [1:0]    WORD_LAST = 2'(WORDS_PER_LANE - 1);

   state_t        state_q;
   logic [BW-1:0] busy_cnt_q;
   logic [3:0]    bit_q;
   logic [1:0]    word_q;
   logic [11:0]   seq_q;
   logic          convst_d_q;
   logic          fs_n_d_q;
   logic          sclk_d_q;
   logic          busy_q;
   logic          overrun_q;
   logic [3:0]    sdo_q;

   logic convst_rise;
   logic fs_fall;
   logic fs_rise;
   logic sclk_fall;

   // The config input is accepted but carries no function in this model.
   logic sdi_unused;
   assign sdi_unused = ad_sdi;

   assign convst_rise = ad_convst & ~convst_d_q;
   assign fs_fall     = ~ad_fs_n & fs_n_d_q;
   assign fs_rise     = ad_fs_n & ~fs_n_d_q;
   assign sclk_fall   = ~ad_sclk & sclk_d_q;

   // Bit number bitn (0 = MSB) of word "word" for all four lanes at once.
   function automatic logic [3:0] lane_bits(input logic [1:0]  word,
                                            input logic [3:0]  bitn,
                                            input logic [11:0] seq);
      logic [15:0] w;
      logic [3:0]  r;
      r = 4'b0000;
      for (int k = 0; k < 4; k++) begin
         w    = {2'(k), word, seq};
         r[k] = w[4'd15 - bitn];
      end
      return r;
   endfunction

   // Edge-detect registers, conversion/frame state machine and registered outputs.
   always_ff @(posedge sys_clk) begin
      if (sys_rst || ad_reset) begin
         state_q    <= IDLE;
         busy_cnt_q <= '0;
         bit_q      <= 4'd0;
         word_q     <= 2'd0;
         seq_q      <= 12'd0;
         convst_d_q <= 1'b0;
         fs_n_d_q   <= 1'b0;
         sclk_d_q   <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         sdo_q      <= 4'b0000;
      end else begin
         convst_d_q <= ad_convst;
         fs_n_d_q   <= ad_fs_n;
         sclk_d_q   <= ad_sclk;

         // A start request while anything is still in flight is only flagged.
         if (convst_rise && (state_q != IDLE)) begin
            overrun_q <= 1'b1;
         end

         case (state_q)
            IDLE: begin
               sdo_q <= 4'b0000;
               if (convst_rise) begin
                  state_q    <= CONV;
                  busy_q     <= 1'b1;
                  busy_cnt_q <= '0;
               end
            end
            CONV: begin
               if (busy_cnt_q == BUSY_LAST) begin
                  busy_q  <= 1'b0;
                  state_q <= READY;
               end else begin
                  busy_cnt_q <= busy_cnt_q + BW'(1);
               end
            end
            READY: begin
               if (fs_fall) begin
                  state_q <= SHIFT;
                  bit_q   <= 4'd0;
                  word_q  <= 2'd0;
                  sdo_q   <= lane_bits(2'd0, 4'd0, seq_q);
               end
            end
            SHIFT: begin
               // An fs_n release wins over a coincident sclk edge.
               if (fs_rise) begin
                  state_q <= IDLE;
                  sdo_q   <= 4'b0000;
                  bit_q   <= 4'd0;
                  word_q  <= 2'd0;
               end else if (sclk_fall) begin
                  if (bit_q == 4'd15) begin
                     bit_q <= 4'd0;
                     if (word_q == WORD_LAST) begin
                        seq_q   <= seq_q + 12'd1;
                        word_q  <= 2'd0;
                        sdo_q   <= 4'b0000;
                        state_q <= IDLE;
                     end else begin
                        word_q <= word_q + 2'd1;
                        sdo_q  <= lane_bits(word_q + 2'd1, 4'd0, seq_q);
                     end
                  end else begin
                     bit_q <= bit_q + 4'd1;
                     sdo_q <= lane_bits(word_q, bit_q + 4'd1, seq_q);
                  end
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ad_busy = busy_q;
   assign ad_sdo  = sdo_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_ads_adc_emu.sv
// Scoreboard bench for ads_adc_emu. The stimulus pushes the expected words,
// busy pulses and status values. The monitor watches the pins, rebuilds
// words and busy pulses, and compares them against the queues.
// A second instance (busy 1, one word per lane) runs the 4096-frame seq wrap.
module tb_ads_adc_emu;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       sys_rst, ad_reset, ad_convst, ad_fs_n, ad_sclk, ad_sdi;
   logic       busy_m, busy_w, ovr_m, ovr_w;
   logic [3:0] sdo_m, sdo_w;
   logic       sel_w;
   logic       m_busy, m_ovr;
   logic [3:0] m_sdo;

   int n_tests = 0;
   int n_fail  = 0;

   logic [63:0] word_exp[$];
   string       word_nm[$];
   int          busy_lat_exp[$];
   int          busy_len_exp[$];
   int          stat_sel[$];
   logic [3:0]  stat_exp[$];
   string       stat_nm[$];

   ads_adc_emu dut (
      .sys_clk(clk), .sys_rst(sys_rst), .ad_reset(ad_reset), .ad_convst(ad_convst),
      .ad_busy(busy_m), .ad_fs_n(ad_fs_n), .ad_sclk(ad_sclk), .ad_sdi(ad_sdi),
      .ad_sdo(sdo_m), .overrun(ovr_m)
   );

   ads_adc_emu #(.BUSY_CYCLES(1), .WORDS_PER_LANE(1)) dut_w (
      .sys_clk(clk), .sys_rst(sys_rst), .ad_reset(ad_reset), .ad_convst(ad_convst),
      .ad_busy(busy_w), .ad_fs_n(ad_fs_n), .ad_sclk(ad_sclk), .ad_sdi(ad_sdi),
      .ad_sdo(sdo_w), .overrun(ovr_w)
   );

   assign m_busy = sel_w ? busy_w : busy_m;
   assign m_ovr  = sel_w ? ovr_w  : ovr_m;
   assign m_sdo  = sel_w ? sdo_w  : sdo_m;

   // Monitor: samples 1 time unit after each rising edge.
   initial begin : monitor
      logic             p_convst, p_fs, p_sclk;
      int               cyc, conv_cyc, blen, blat, nbits;
      bit               in_busy, in_frame;
      logic [3:0][15:0] acc;
      logic [3:0][15:0] e;
      logic [3:0]       got;
      int               sel, lat, len;
      string            nm;
      p_convst = 1'b0; p_fs = 1'b1; p_sclk = 1'b1;
      cyc = 0; conv_cyc = -1; blen = 0; blat = -1; nbits = 0;
      in_busy = 1'b0; in_frame = 1'b0; acc = '0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         while (stat_sel.size() > 0) begin
            sel = stat_sel.pop_front();
            nm  = stat_nm.pop_front();
            e[0][3:0] = stat_exp.pop_front();
            got = (sel == 0) ? m_sdo : (sel == 1) ? {3'b000, m_busy} : {3'b000, m_ovr};
            n_tests++;
            if (got !== e[0][3:0]) begin
               n_fail++;
               $display("FAIL %s: got %h, want %h", nm, got, e[0][3:0]);
            end
         end
         if (sys_rst || ad_reset) begin
            in_frame = 1'b0; in_busy = 1'b0; conv_cyc = -1;
         end else begin
            if (ad_convst && !p_convst && !in_busy) conv_cyc = cyc;
            if (m_busy && !in_busy) begin
               in_busy = 1'b1; blen = 1;
               blat = (conv_cyc < 0) ? -1 : cyc - conv_cyc + 1;
            end else if (m_busy && in_busy) begin
               blen++;
            end else if (!m_busy && in_busy) begin
               in_busy = 1'b0; conv_cyc = -1;
               n_tests++;
               if (busy_len_exp.size() == 0) begin
                  n_fail++;
                  $display("FAIL busy_unexpected: got pulse of %0d cycles, want none", blen);
               end else begin
                  lat = busy_lat_exp.pop_front();
                  len = busy_len_exp.pop_front();
                  if (blat != lat) begin
                     n_fail++;
                     $display("FAIL busy_latency: got %0d, want %0d", blat, lat);
                  end
                  n_tests++;
                  if (blen != len) begin
                     n_fail++;
                     $display("FAIL busy_length: got %0d, want %0d", blen, len);
                  end
               end
            end
            if (in_frame && ad_fs_n && !p_fs) begin
               in_frame = 1'b0;
            end else if ((!ad_fs_n && p_fs) || (in_frame && !ad_sclk && p_sclk)) begin
               if (!ad_fs_n && p_fs) begin
                  in_frame = 1'b1; nbits = 0;
               end
               for (int k = 0; k < 4; k++) acc[k] = {acc[k][14:0], m_sdo[k]};
               nbits++;
               if (nbits == 16) begin
                  nbits = 0;
                  if (word_exp.size() == 0) begin
                     n_tests++; n_fail++;
                     $display("FAIL word_unexpected: got %h, want none", acc);
                  end else begin
                     e  = word_exp.pop_front();
                     nm = word_nm.pop_front();
                     for (int k = 0; k < 4; k++) begin
                        n_tests++;
                        if (acc[k] !== e[k]) begin
                           n_fail++;
                           $display("FAIL %s lane%0d: got %h, want %h", nm, k, acc[k], e[k]);
                        end
                     end
                  end
               end
            end
         end
         p_convst = ad_convst; p_fs = ad_fs_n; p_sclk = ad_sclk;
      end
   end

   task automatic stat(input int sel, input logic [3:0] v, input string nm);
      stat_sel.push_back(sel); stat_exp.push_back(v); stat_nm.push_back(nm);
   endtask

   task automatic wait_busy_low(input int limit);
      bit done;
      done = 1'b0;
      for (int i = 0; i < limit; i++) begin
         if (!m_busy) begin
            done = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_tests++;
      if (!done) begin
         n_fail++;
         $display("FAIL busy_timeout: got busy %b after %0d cycles, want 0", m_busy, limit);
      end
   endtask

   task automatic do_conv(input int len, input int limit);
      busy_lat_exp.push_back(1); busy_len_exp.push_back(len);
      @(negedge clk); ad_convst = 1'b1;
      @(negedge clk); ad_convst = 1'b0;
      wait_busy_low(limit);
   endtask

   task automatic run_frame(input int nedges, input int ph);
      @(negedge clk); ad_fs_n = 1'b0;
      @(negedge clk);
      for (int i = 0; i < nedges; i++) begin
         ad_sclk = 1'b0;
         repeat (ph) @(negedge clk);
         ad_sclk = 1'b1;
         repeat (ph) @(negedge clk);
      end
   endtask

   task automatic full_frame(input logic [63:0] w0, input logic [63:0] w1,
                             input int words, input int ph, input string nm);
      word_exp.push_back(w0); word_nm.push_back({nm, "_w0"});
      if (words > 1) begin
         word_exp.push_back(w1); word_nm.push_back({nm, "_w1"});
      end
      run_frame(16 * words, ph);
      ad_fs_n = 1'b1;
      stat(0, 4'h0, {nm, "_end_sdo"});
   endtask

   // Directed stimulus.
   initial begin
      logic [11:0] s;
      sel_w = 1'b0; sys_rst = 1'b1; ad_reset = 1'b0; ad_convst = 1'b0;
      ad_fs_n = 1'b1; ad_sclk = 1'b1; ad_sdi = 1'b1;
      @(negedge clk);
      stat(0, 4'h0, "rst_sdo"); stat(1, 4'h0, "rst_busy"); stat(2, 4'h0, "rst_ovr");
      @(negedge clk); sys_rst = 1'b0;

      // Conversion followed by a complete two-word frame, seq 0.
      do_conv(54, 200);
      full_frame(64'hC000_8000_4000_0000, 64'hD000_9000_5000_1000, 2, 2, "frame0");
      stat(1, 4'h0, "frame0_busy");

      // Abort after 10 edges, with fs_n rising on the same cycle as an sclk fall.
      do_conv(54, 200);
      run_frame(10, 2);
      @(negedge clk); ad_sclk = 1'b0; ad_fs_n = 1'b1; stat(0, 4'h0, "abort_sdo");
      @(negedge clk); ad_sclk = 1'b1; stat(2, 4'h0, "abort_ovr");
      do_conv(54, 200);
      full_frame(64'hC001_8001_4001_0001, 64'hD001_9001_5001_1001, 2, 2, "after_abort");

      // Overrun: a second convst edge during busy cycle 20.
      busy_lat_exp.push_back(1); busy_len_exp.push_back(54);
      @(negedge clk); ad_convst = 1'b1;
      @(negedge clk); ad_convst = 1'b0;
      repeat (19) @(negedge clk);
      ad_convst = 1'b1;
      @(negedge clk); ad_convst = 1'b0;
      wait_busy_low(200);
      stat(2, 4'h1, "ovr_set");
      @(negedge clk); sys_rst = 1'b1; stat(2, 4'h0, "ovr_clr");
      @(negedge clk); sys_rst = 1'b0;

      // Device reset in the middle of word 0 (bit 7), after one full frame.
      do_conv(54, 200);
      full_frame(64'hC000_8000_4000_0000, 64'hD000_9000_5000_1000, 2, 2, "pre_rst");
      do_conv(54, 200);
      run_frame(7, 2);
      @(negedge clk); ad_reset = 1'b1;
      stat(0, 4'h0, "mid_rst_sdo"); stat(1, 4'h0, "mid_rst_busy");
      @(negedge clk); ad_reset = 1'b0; ad_fs_n = 1'b1;
      do_conv(54, 200);
      full_frame(64'hC000_8000_4000_0000, 64'hD000_9000_5000_1000, 2, 2, "post_rst");

      // Frame counter wrap on the short instance. Single-cycle sclk phases
      // keep the 4097 frames short.
      @(negedge clk); sys_rst = 1'b1;
      @(negedge clk); sys_rst = 1'b0; sel_w = 1'b1;
      for (int f = 0; f <= 4096; f++) begin
         s = 12'(f);
         do_conv(1, 20);
         full_frame({4'hC, s, 4'h8, s, 4'h4, s, 4'h0, s}, 64'h0, 1, 1, $sformatf("wrap%0d", f));
      end

      repeat (4) @(negedge clk);
      n_tests++;
      if (word_exp.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_words: got %0d entries, want 0", word_exp.size());
      end
      n_tests++;
      if (busy_len_exp.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_busy: got %0d entries, want 0", busy_len_exp.size());
      end
      n_tests++;
      if (stat_sel.size() != 0) begin
         n_fail++;
         $display("FAIL leftover_status: got %0d entries, want 0", stat_sel.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/ads_adc_emu.md
ADS_ADC_EMU -- requirements
Module: ads_adc_emu

Interface
REQ-001 The block SHALL have parameter BUSY_CYCLES, default 54: number of sys_clk cycles ad_busy is held high per conversion.
REQ-002 The block SHALL have parameter WORDS_PER_LANE, default 2, legal range 1..4: 16-bit words shifted per SDO lane per frame.
REQ-003 The block SHALL have port sys_clk  in  1  the single clock; every register is clocked on its rising edge.
REQ-004 The block SHALL have port sys_rst  in  1  synchronous, active-high reset.
REQ-005 The block SHALL have port ad_reset  in  1  device reset from the controller, synchronous, active-high.
REQ-006 The block SHALL have port ad_convst  in  1  conversion start; a rising edge starts a conversion.
REQ-007 The block SHALL have port ad_busy  out  1  high while a conversion is in progress.
REQ-008 The block SHALL have port ad_fs_n  in  1  frame sync, active-low.
REQ-009 The block SHALL have port ad_sclk  in  1  serial clock, synchronous to sys_clk, with at least 2 sys_clk cycles per phase.
REQ-010 The block SHALL have port ad_sdi  in  1  config input; it is accepted and ignored.
REQ-011 The block SHALL have port ad_sdo  out  4  serial data, one lane per bit, MSB first.
REQ-012 The block SHALL have port overrun  out  1  sticky flag: a convst rising edge arrived while the block was not in IDLE.

Function
REQ-013 The block SHALL register ad_convst, ad_fs_n and ad_sclk once (x_d) for edge detection; edges are computed from the current input and its x_d.
REQ-014 The state machine SHALL have four states: IDLE, CONV, READY, SHIFT.
REQ-015 IDLE -> CONV on a convst rising edge; ad_busy SHALL go high on the following cycle.
REQ-016 CONV SHALL hold ad_busy high for exactly BUSY_CYCLES cycles, then drive ad_busy low and enter READY.
REQ-017 READY -> SHIFT on an fs_n falling edge; at that clock edge the block SHALL load word 0 for every lane and drive ad_sdo[k] with the MSB of its word.
REQ-018 Word content for lane k (0..3), word index j: {k[1:0], j[1:0], seq[11:0]}; seq is a 12-bit frame counter, reset value 0.
REQ-019 In SHIFT, each sclk falling edge (ad_sclk==0, sclk_d==1) SHALL advance the bit counter and drive the next bit on ad_sdo, registered at that clock edge.
REQ-020 After the 16th falling edge of a word (bit counter wraps 15->0), the block SHALL load word j+1 and drive its MSB on the same edge.
REQ-021 A frame completes on the 16*WORDS_PER_LANE-th falling edge; the block SHALL then increment seq (mod 4096), drive ad_sdo 0 and return to IDLE.
REQ-022 An fs_n rising edge in SHIFT before frame completion SHALL abort: return to IDLE, ad_sdo 0, seq unchanged.
REQ-023 When a bit shift and an fs_n rising edge occur in the same cycle, the abort SHALL take priority.
REQ-024 sclk edges in IDLE, CONV or READY SHALL be ignored; ad_sdo SHALL be 0 outside SHIFT.
REQ-025 A convst rising edge in CONV, READY or SHIFT SHALL be ignored for sequencing and SHALL set overrun; overrun SHALL clear only on reset.
REQ-026 An fs_n falling edge in IDLE or CONV SHALL be ignored (no data while busy or before a conversion).

Reset
REQ-027 sys_rst or ad_reset high at a rising clock edge SHALL force the following values on the next cycle, from any state including mid-frame: state IDLE, ad_busy 0, ad_sdo 4'b0000, seq 0, bit/word counters 0, overrun 0, edge registers 0.
REQ-028 While ad_reset is high, convst, fs_n and sclk edges SHALL be ignored.

Verification
REQ-029 The bench SHALL check the conversion cycle: reset, then convst rising edge -> ad_busy high 1 cycle later for exactly 54 cycles, then low.
REQ-030 The bench SHALL check a full frame: after busy falls, fs_n low and 32 sclk falling edges -> lane0 bits = 16'h0000 then 16'h1000; lane3 = 16'hC000 then 16'hD000; then IDLE, ad_sdo 0.
REQ-031 The bench SHALL check seq wrap: 4096 full frames -> next frame's lane0 word0 = 16'h0000; frame 4095's lane0 word0 = 16'h0FFF.
REQ-032 The bench SHALL check an aborted frame: fs_n rises after 10 falling edges -> IDLE, ad_sdo 0; the next frame's lane0 word0 = 16'h0001 when the prior full-frame count is 1.
REQ-033 The bench SHALL check overrun: convst edge at busy cycle 20 -> overrun 1, busy duration still 54; sys_rst -> overrun 0.
REQ-034 The bench SHALL check reset mid-frame: ad_reset pulse at bit 7 of word 0 -> next cycle ad_sdo 0 and ad_busy 0; the following frame's lane1 word0 = 16'h4000.
